dm_unit: RTL and testbench

- Data-memory stage of the 5-stage MIPS pipeline, sitting between EX_MEM and the MEM/WB pipeline register.
- Holds the data RAM and performs byte-enabled stores (sw/sh/sb).
- Supplies the raw aligned read word and byte offset that the MEM/WB register captures as MemRDM/ByteSelM.
- Flags misaligned or out-of-range accesses as address exceptions.

---
 rtl/dm_unit_pkg.sv | 48 ++++
 rtl/dm_unit_if.sv | 31 +++
 rtl/dm_byte_en.sv | 37 +++
 rtl/dm_unit.sv | 83 ++++++++
 tb/tb_dm_unit.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/dm_unit_pkg.sv
// dm_unit_pkg: constants shared by the data-memory stage, the controller and
// the write-back extender.
//   - WORD_W: machine word width.
//   - store_t / load_t: store and load type encodings carried down the pipeline.
//   - st_aligned / ld_aligned / ld_valid: helpers for the address-exception checks.
package dm_unit_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      ST_NONE = 2'd0,
      ST_W    = 2'd1,
      ST_H    = 2'd2,
      ST_B    = 2'd3
   } store_t;

   typedef enum logic [2:0] {
      LD_NONE = 3'd0,
      LD_W    = 3'd1,
      LD_H    = 3'd2,
      LD_HU   = 3'd3,
      LD_B    = 3'd4,
      LD_BU   = 3'd5
   } load_t;

   // Word accesses need both offset bits clear, halfwords need bit 0 clear.
   function automatic logic st_aligned(input logic [1:0] st, input logic [1:0] off);
      logic ok;
      ok = 1'b1;
      if (st == ST_W)      ok = (off == 2'b00);
      else if (st == ST_H) ok = ~off[0];
      return ok;
   endfunction

   function automatic logic ld_aligned(input logic [2:0] ld, input logic [1:0] off);
      logic ok;
      ok = 1'b1;
      if (ld == LD_W)                      ok = (off == 2'b00);
      else if (ld == LD_H || ld == LD_HU)  ok = ~off[0];
      return ok;
   endfunction

   // Codes 6 and 7 are not decoded and behave like "no load".
   function automatic logic ld_valid(input logic [2:0] ld);
      return (ld != LD_NONE) && (ld <= LD_BU);
   endfunction

endpackage

// File: rtl/dm_unit_if.sv
// dm_unit_if: EX_MEM -> data-memory -> MEM/WB signal bundle.
//   master: pipeline side, drives the request and samples the results.
//   slave : dm_unit side, consumes the request and drives the results.
// Request : MemWriteM, StoreTypeM, MemReadM, LoadTypeM, AddrM, WDM, PCM
// Result  : MemRDM, ByteSelM, ByteEnM, AdELM, AdESM
interface dm_unit_if;
   import dm_unit_pkg::*;

   logic              MemWriteM;
   logic [1:0]        StoreTypeM;
   logic              MemReadM;
   logic [2:0]        LoadTypeM;
   logic [WORD_W-1:0] AddrM;
   logic [WORD_W-1:0] WDM;
   logic [WORD_W-1:0] PCM;
   logic [WORD_W-1:0] MemRDM;
   logic [1:0]        ByteSelM;
   logic [3:0]        ByteEnM;
   logic              AdELM;
   logic              AdESM;

   modport master (
      output MemWriteM, StoreTypeM, MemReadM, LoadTypeM, AddrM, WDM, PCM,
      input  MemRDM, ByteSelM, ByteEnM, AdELM, AdESM
   );

   modport slave (
      input  MemWriteM, StoreTypeM, MemReadM, LoadTypeM, AddrM, WDM, PCM,
      output MemRDM, ByteSelM, ByteEnM, AdELM, AdESM
   );
endinterface

// File: rtl/dm_byte_en.sv
// dm_byte_en: combinational store-lane steering.
//   store_type : store type code (ST_*)
//   offset     : byte offset AddrM[1:0]
//   wd         : store data, low bytes significant for sh/sb
//   en_raw     : byte enables before exception/request masking
//   lane_data  : store data replicated so every lane carries the right byte
module dm_byte_en
   import dm_unit_pkg::*;
(
   input  logic [1:0]        store_type,
   input  logic [1:0]        offset,
   input  logic [WORD_W-1:0] wd,
   output logic [3:0]        en_raw,
   output logic [WORD_W-1:0] lane_data
);

   always_comb begin
      en_raw    = 4'b0000;
      lane_data = wd;
      case (store_type)
         ST_W: begin
            en_raw    = 4'b1111;
            lane_data = wd;
         end
         ST_H: begin
            en_raw    = 4'b0011 << offset;
            lane_data = {2{wd[15:0]}};
         end
         ST_B: begin
            en_raw    = 4'b0001 << offset;
            lane_data = {4{wd[7:0]}};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dm_unit.sv
// dm_unit: data-memory stage of the 5-stage MIPS pipeline.
// Holds the data RAM, applies byte-enabled stores on the clock edge and
// presents the raw aligned word asynchronously for the MEM/WB register.
//   clk   : clock
//   reset : synchronous, active-high; clears the whole RAM
//   bus   : dm_unit_if.slave (request in, MemRDM/ByteSelM/ByteEnM/AdELM/AdESM out)
// All outputs are combinational.
module dm_unit
   import dm_unit_pkg::*;
#(
   parameter int          DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic      clk,
   input  logic      reset,
   dm_unit_if.slave  bus
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   logic [WORD_W-1:0] mem [DEPTH_WORDS];

   logic [31:0]       offs;
   logic [31:0]       idx;
   logic [IDX_W-1:0]  widx;
   logic              in_range;
   logic              st_req;
   logic              ld_req;
   logic [3:0]        en_raw;
   logic [3:0]        byte_en;
   logic [WORD_W-1:0] lane_data;
   logic [WORD_W-1:0] mask;
   logic [WORD_W-1:0] rd_word;
   logic [WORD_W-1:0] merged;

   assign offs     = bus.AddrM - BASE_ADDR;
   assign idx      = offs >> 2;
   assign widx     = idx[IDX_W-1:0];
   assign in_range = (bus.AddrM >= BASE_ADDR) && (idx < 32'(DEPTH_WORDS));

   assign st_req = bus.MemWriteM && (bus.StoreTypeM != ST_NONE);
   assign ld_req = bus.MemReadM && ld_valid(bus.LoadTypeM);

   assign bus.AdESM = st_req && (!st_aligned(bus.StoreTypeM, bus.AddrM[1:0]) || !in_range);
   assign bus.AdELM = ld_req && (!ld_aligned(bus.LoadTypeM, bus.AddrM[1:0]) || !in_range);

   dm_byte_en u_byte_en (
      .store_type (bus.StoreTypeM),
      .offset     (bus.AddrM[1:0]),
      .wd         (bus.WDM),
      .en_raw     (en_raw),
      .lane_data  (lane_data)
   );

   // Faulting, absent or reset-coincident stores must not touch the RAM.
   assign byte_en = (st_req && !bus.AdESM && !reset) ? en_raw : 4'b0000;

   assign mask = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};

   // Out-of-range addresses never index the array; the read returns zero.
   assign rd_word = in_range ? mem[widx] : '0;
   assign merged  = (rd_word & ~mask) | (lane_data & mask);

   assign bus.MemRDM   = rd_word;
   assign bus.ByteSelM = bus.AddrM[1:0];
   assign bus.ByteEnM  = byte_en;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
      end else if (byte_en != 4'b0000) begin
         mem[widx] <= merged;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!reset && byte_en != 4'b0000)
         $display("@%h: *%h <= %h", bus.PCM, {bus.AddrM[31:2], 2'b00}, merged);
   end
`endif

endmodule

// File: tb/tb_dm_unit.sv
module tb_dm_unit;
   import dm_unit_pkg::*;

   localparam int          DEPTH = 4096;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   dm_unit_if bus ();

   dm_unit #(
      .DEPTH_WORDS (DEPTH),
      .BASE_ADDR   (BASE)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic mw, input logic [1:0] st, input logic mr,
                        input logic [2:0] ld, input logic [31:0] addr,
                        input logic [31:0] wd);
      bus.MemWriteM  = mw;
      bus.StoreTypeM = st;
      bus.MemReadM   = mr;
      bus.LoadTypeM  = ld;
      bus.AddrM      = addr;
      bus.WDM        = wd;
      bus.PCM        = 32'h0040_0000 + addr;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      drive(1'b0, ST_NONE, 1'b0, LD_NONE, 32'h0, 32'h0);
      tick();
      tick();
      reset = 1'b0;
      #1;

      // Idle after reset
      check("rst_rd",    bus.MemRDM, 32'h0);
      check("rst_bsel",  32'(bus.ByteSelM), 32'h0);
      check("rst_ben",   32'(bus.ByteEnM), 32'h0);
      check("rst_adel",  32'(bus.AdELM), 32'h0);
      check("rst_ades",  32'(bus.AdESM), 32'h0);

      drive(1'b0, ST_NONE, 1'b1, LD_W, 32'h10, 32'h0);
      check("rd10_zero", bus.MemRDM, 32'h0);
      check("rd10_adel", 32'(bus.AdELM), 32'h0);

      // sw then read back
      drive(1'b1, ST_W, 1'b0, LD_NONE, 32'h10, 32'hDEAD_BEEF);
      check("sw_ben",    32'(bus.ByteEnM), 32'hF);
      check("sw_ades",   32'(bus.AdESM), 32'h0);
      check("sw_oldrd",  bus.MemRDM, 32'h0);
      tick();
      drive(1'b0, ST_NONE, 1'b1, LD_W, 32'h10, 32'h0);
      check("sw_rdback", bus.MemRDM, 32'hDEAD_BEEF);

      // sb to lane 3, sh to lanes 1:0
      drive(1'b1, ST_B, 1'b0, LD_NONE, 32'h13, 32'h0000_0055);
      check("sb_ben",    32'(bus.ByteEnM), 32'h8);
      check("sb_bsel",   32'(bus.ByteSelM), 32'h3);
      tick();
      drive(1'b1, ST_H, 1'b0, LD_NONE, 32'h10, 32'h0000_AAAA);
      check("sh_ben",    32'(bus.ByteEnM), 32'h3);
      check("sh_oldrd",  bus.MemRDM, 32'h55AD_BEEF);
      tick();
      drive(1'b0, ST_NONE, 1'b1, LD_W, 32'h10, 32'h0);
      check("merge_rd",  bus.MemRDM, 32'h55AD_AAAA);

      // Upper halfword store
      drive(1'b1, ST_H, 1'b0, LD_NONE, 32'h12, 32'hFFFF_1234);
      check("sh2_ben",   32'(bus.ByteEnM), 32'hC);
      tick();
      drive(1'b0, ST_NONE, 1'b1, LD_BU, 32'h13, 32'h0);
      check("sh2_rd",    bus.MemRDM, 32'h1234_AAAA);
      check("sh2_bsel",  32'(bus.ByteSelM), 32'h3);

      // Misaligned accesses
      drive(1'b1, ST_W, 1'b0, LD_NONE, 32'h12, 32'h1111_1111);
      check("mis_ades",  32'(bus.AdESM), 32'h1);
      check("mis_ben",   32'(bus.ByteEnM), 32'h0);
      tick();
      drive(1'b0, ST_NONE, 1'b1, LD_H, 32'h11, 32'h0);
      check("mis_keep",  bus.MemRDM, 32'h1234_AAAA);
      check("lh_adel",   32'(bus.AdELM), 32'h1);
      drive(1'b0, ST_NONE, 1'b1, LD_B, 32'h11, 32'h0);
      check("lb_adel",   32'(bus.AdELM), 32'h0);
      drive(1'b0, ST_NONE, 1'b1, LD_W, 32'h12, 32'h0);
      check("lw_adel",   32'(bus.AdELM), 32'h1);
      drive(1'b0, ST_NONE, 1'b1, 3'd6, 32'h11, 32'h0);
      check("illld_adel", 32'(bus.AdELM), 32'h0);
      drive(1'b1, ST_H, 1'b0, LD_NONE, 32'h11, 32'h0000_7777);
      check("sh_mis_ades", 32'(bus.AdESM), 32'h1);
      check("sh_mis_ben",  32'(bus.ByteEnM), 32'h0);

      // Store request with StoreType none
      drive(1'b1, ST_NONE, 1'b0, LD_NONE, 32'h10, 32'h9999_9999);
      check("stnone_ben",  32'(bus.ByteEnM), 32'h0);
      check("stnone_ades", 32'(bus.AdESM), 32'h0);
      tick();

      // Out of range, one past the last word
      drive(1'b1, ST_W, 1'b0, LD_NONE, BASE + 32'(4 * DEPTH), 32'hCAFE_F00D);
      check("oor_ades",  32'(bus.AdESM), 32'h1);
      check("oor_ben",   32'(bus.ByteEnM), 32'h0);
      tick();
      drive(1'b0, ST_NONE, 1'b1, LD_W, BASE + 32'(4 * DEPTH), 32'h0);
      check("oor_rd",    bus.MemRDM, 32'h0);
      check("oor_adel",  32'(bus.AdELM), 32'h1);
      drive(1'b0, ST_NONE, 1'b1, LD_W, BASE, 32'h0);
      check("oor_alias", bus.MemRDM, 32'h0);

      // Last valid word
      drive(1'b1, ST_W, 1'b0, LD_NONE, BASE + 32'(4 * DEPTH - 4), 32'hA5A5_5A5A);
      check("last_ades", 32'(bus.AdESM), 32'h0);
      check("last_ben",  32'(bus.ByteEnM), 32'hF);
      tick();
      drive(1'b0, ST_NONE, 1'b1, LD_W, BASE + 32'(4 * DEPTH - 4), 32'h0);
      check("last_rd",   bus.MemRDM, 32'hA5A5_5A5A);

      // Store and read of the same word, with both exception checks active
      drive(1'b1, ST_W, 1'b1, LD_W, 32'h20, 32'h1234_5678);
      check("rw_old",    bus.MemRDM, 32'h0);
      check("rw_ben",    32'(bus.ByteEnM), 32'hF);
      check("rw_adel",   32'(bus.AdELM), 32'h0);
      tick();
      drive(1'b0, ST_NONE, 1'b1, LD_W, 32'h20, 32'h0);
      check("rw_new",    bus.MemRDM, 32'h1234_5678);

      // Reset on the same edge as a store: reset wins and clears RAM
      drive(1'b1, ST_W, 1'b0, LD_NONE, 32'h24, 32'h8765_4321);
      reset = 1'b1;
      #1;
      check("rst_st_ben", 32'(bus.ByteEnM), 32'h0);
      tick();
      reset = 1'b0;
      drive(1'b0, ST_NONE, 1'b1, LD_W, 32'h24, 32'h0);
      check("rst_st_rd", bus.MemRDM, 32'h0);
      drive(1'b0, ST_NONE, 1'b1, LD_W, 32'h20, 32'h0);
      check("rst_clr20", bus.MemRDM, 32'h0);
      drive(1'b0, ST_NONE, 1'b1, LD_W, 32'h10, 32'h0);
      check("rst_clr10", bus.MemRDM, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
